regfile_mp: RTL and testbench

Parametrised multi-port general-purpose register file for the next-generation CPU core. It replaces the single-write, two-read register file and adds:
- configurable width, depth and read-port count;
- a second write port for long-latency units (multiplier/divider write-back);
- optional same-cycle write-to-read bypass;
- a per-register pending-write scoreboard;
- a sequenced soft-clear engine.

It sits between decode (read ports, scoreboard) and write-back (port A: ALU/memory, port B: multicycle units).

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_mp_if.sv | 38 +++
 rtl/regfile_clr_seq.sv | 48 ++++
 rtl/regfile_mp.sv | 106 ++++++++++
 tb/tb_regfile_mp.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DEF_DW    = 32;
  localparam int unsigned DEF_AW    = 5;
  localparam int unsigned DEF_NR    = 2;
  localparam int unsigned ZERO_ADDR = 0;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/write-back side bus of the register file: read ports, two write ports, scoreboard, clear.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned NR = DEF_NR
) ();

  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic             wa_en;
  logic [AW-1:0]    wa_addr;
  logic [DW-1:0]    wa_data;
  logic             wa_cancel;
  logic             wb_en;
  logic [AW-1:0]    wb_addr;
  logic [DW-1:0]    wb_data;
  logic             sb_set;
  logic [AW-1:0]    sb_addr;
  logic             clr_req;
  logic             clr_busy;
  logic             ready;

  modport master (
    output rd_addr, wa_en, wa_addr, wa_data, wa_cancel,
    output wb_en, wb_addr, wb_data, sb_set, sb_addr, clr_req,
    input  rd_data, rd_busy, clr_busy, ready
  );

  modport slave (
    input  rd_addr, wa_en, wa_addr, wa_data, wa_cancel,
    input  wb_en, wb_addr, wb_data, sb_set, sb_addr, clr_req,
    output rd_data, rd_busy, clr_busy, ready
  );

endinterface

// File: rtl/regfile_clr_seq.sv
// Soft-clear sequencer: walks idx over every register once after a clear request.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int unsigned AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr_req,
  output logic          o_clr_busy,
  output logic          o_clr_we,
  output logic [AW-1:0] o_clr_idx
);

  localparam int unsigned DEPTH = 2**AW;

  clr_state_e    r_state;
  logic [AW-1:0] r_idx;

  // Requests arriving mid-sweep are ignored; idx wraps to 0 on the final entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_clr_req) begin
            r_state <= CLEAR;
            r_idx   <= '0;
          end
        end
        CLEAR: begin
          r_idx <= r_idx + AW'(1);
          if (r_idx == AW'(DEPTH - 1)) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_clr_busy = (r_state == CLEAR);
  assign o_clr_we   = (r_state == CLEAR);
  assign o_clr_idx  = r_idx;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port GPR file: two write ports, optional bypass, pending-write scoreboard, soft clear.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DW       = DEF_DW,
  parameter int unsigned AW       = DEF_AW,
  parameter int unsigned NR       = DEF_NR,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);

  localparam int unsigned DEPTH = 2**AW;

  logic [DW-1:0]    r_mem [DEPTH];
  logic [DEPTH-1:0] r_sb;
  logic             r_rst_q;

  logic             w_clr_busy;
  logic             w_clr_we;
  logic [AW-1:0]    w_clr_idx;
  logic             w_idle;
  logic             w_wa_eff;
  logic             w_wb_eff;
  logic             w_wb_commit;
  logic             w_sb_set;

  regfile_clr_seq #(.AW(AW)) u_clr_seq (
    .clk        (clk),
    .rst        (rst),
    .i_clr_req  (bus.clr_req),
    .o_clr_busy (w_clr_busy),
    .o_clr_we   (w_clr_we),
    .o_clr_idx  (w_clr_idx)
  );

  // A B write that loses to A on the same address is dropped but still clears its scoreboard bit.
  always_comb begin
    w_idle      = !w_clr_busy && !rst;
    w_wa_eff    = bus.wa_en && !bus.wa_cancel && w_idle &&
                  !(ZERO_REG && (bus.wa_addr == AW'(ZERO_ADDR)));
    w_wb_eff    = bus.wb_en && w_idle &&
                  !(ZERO_REG && (bus.wb_addr == AW'(ZERO_ADDR)));
    w_wb_commit = w_wb_eff && !(w_wa_eff && (bus.wa_addr == bus.wb_addr));
    w_sb_set    = bus.sb_set && w_idle &&
                  !(ZERO_REG && (bus.sb_addr == AW'(ZERO_ADDR)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem <= '{default: '0};
    end else if (w_clr_we) begin
      r_mem[w_clr_idx] <= '0;
    end else begin
      if (w_wb_commit) r_mem[bus.wb_addr] <= bus.wb_data;
      if (w_wa_eff)    r_mem[bus.wa_addr] <= bus.wa_data;
    end
  end

  // Set is applied after clear so a same-address set wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sb <= '0;
    end else if (w_clr_we) begin
      r_sb[w_clr_idx] <= 1'b0;
    end else begin
      if (w_wb_eff) r_sb[bus.wb_addr] <= 1'b0;
      if (w_sb_set) r_sb[bus.sb_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    r_rst_q <= rst;
  end

  assign bus.clr_busy = w_clr_busy;
  assign bus.ready    = !w_clr_busy && !r_rst_q && !rst;

  for (genvar gi = 0; gi < NR; gi++) begin : g_rd
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_stored;
    logic [DW-1:0] w_fwd;

    assign w_addr = bus.rd_addr[gi*AW +: AW];

    always_comb begin
      w_stored = r_mem[w_addr];
      if (ZERO_REG && (w_addr == AW'(ZERO_ADDR))) w_stored = '0;
      w_fwd = w_stored;
      if (BYPASS) begin
        if (w_wa_eff && (bus.wa_addr == w_addr)) begin
          w_fwd = bus.wa_data;
        end else if (w_wb_commit && (bus.wb_addr == w_addr)) begin
          w_fwd = bus.wb_data;
        end
      end
    end

    assign bus.rd_data[gi*DW +: DW] = w_clr_busy ? '0 : w_fwd;
    assign bus.rd_busy[gi]          = w_clr_busy | r_sb[w_addr];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing and one non-bypassing instance on shared stimulus.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  regfile_mp_if #(.DW(DW), .AW(AW), .NR(NR)) b1 ();
  regfile_mp_if #(.DW(DW), .AW(AW), .NR(NR)) b0 ();

  regfile_mp #(.DW(DW), .AW(AW), .NR(NR), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_byp (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  regfile_mp #(.DW(DW), .AW(AW), .NR(NR), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nobyp (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  assign b0.rd_addr   = b1.rd_addr;
  assign b0.wa_en     = b1.wa_en;
  assign b0.wa_addr   = b1.wa_addr;
  assign b0.wa_data   = b1.wa_data;
  assign b0.wa_cancel = b1.wa_cancel;
  assign b0.wb_en     = b1.wb_en;
  assign b0.wb_addr   = b1.wb_addr;
  assign b0.wb_data   = b1.wb_data;
  assign b0.sb_set    = b1.sb_set;
  assign b0.sb_addr   = b1.sb_addr;
  assign b0.clr_req   = b1.clr_req;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b1.wa_en     = 1'b0;
    b1.wa_cancel = 1'b0;
    b1.wb_en     = 1'b0;
    b1.sb_set    = 1'b0;
    b1.clr_req   = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    for (int a = 0; a < 32; a++) begin
      b1.rd_addr = {AW'(31 - a), AW'(a)};
      #1;
      chk({tag, "_data"}, 64'(b1.rd_data), 64'(0));
      chk({tag, "_busy"}, 64'(b1.rd_busy), 64'(0));
      chk({tag, "_nobyp"}, 64'(b0.rd_data), 64'(0));
    end
  endtask

  task automatic fill();
    for (int i = 1; i < 32; i++) begin
      b1.wa_en   = 1'b1;
      b1.wa_addr = AW'(i);
      b1.wa_data = 32'h1000 + DW'(i);
      tick();
    end
    b1.wa_en = 1'b0;
  endtask

  initial begin
    n_assert     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    b1.rd_addr   = '0;
    b1.wa_addr   = '0;
    b1.wa_data   = '0;
    b1.wb_addr   = '0;
    b1.wb_data   = '0;
    b1.sb_addr   = '0;
    idle_inputs();
    tick();
    tick();

    // Reset and rst_q window
    b1.rd_addr = {5'd7, 5'd5};
    #1;
    chk("rst_rd_data", 64'(b1.rd_data), 64'(0));
    chk("rst_rd_busy", 64'(b1.rd_busy), 64'(0));
    chk("rst_clr_busy", 64'(b1.clr_busy), 64'(0));
    chk("rst_ready", 64'(b1.ready), 64'(0));
    rst = 1'b0;
    #1;
    chk("rstq_ready", 64'(b1.ready), 64'(0));
    chk("rstq_rd_data", 64'(b1.rd_data), 64'(0));
    chk("rstq_clr_busy", 64'(b1.clr_busy), 64'(0));
    tick();
    chk("ready_after_rst", 64'(b1.ready), 64'(1));
    chk_all_zero("init_zero");

    // Basic write, bypass, and r0
    b1.rd_addr = {5'd0, 5'd5};
    b1.wa_en   = 1'b1;
    b1.wa_addr = 5'd5;
    b1.wa_data = 32'hDEADBEEF;
    #1;
    chk("t1_byp_same", 64'(b1.rd_data[31:0]), 64'(32'hDEADBEEF));
    chk("t1_nobyp_same", 64'(b0.rd_data[31:0]), 64'(0));
    tick();
    b1.wa_en = 1'b0;
    #1;
    chk("t1_r5_byp", 64'(b1.rd_data[31:0]), 64'(32'hDEADBEEF));
    chk("t1_r5_nobyp", 64'(b0.rd_data[31:0]), 64'(32'hDEADBEEF));
    b1.wa_en   = 1'b1;
    b1.wa_addr = 5'd0;
    b1.wa_data = 32'h1;
    #1;
    chk("t1_r0_same", 64'(b1.rd_data[63:32]), 64'(0));
    tick();
    b1.wa_en = 1'b0;
    #1;
    chk("t1_r0_byp", 64'(b1.rd_data[63:32]), 64'(0));
    chk("t1_r0_nobyp", 64'(b0.rd_data[63:32]), 64'(0));

    // A and B collide on r7
    b1.rd_addr = {5'd7, 5'd5};
    b1.wa_en   = 1'b1;
    b1.wa_addr = 5'd7;
    b1.wa_data = 32'h11;
    b1.wb_en   = 1'b1;
    b1.wb_addr = 5'd7;
    b1.wb_data = 32'h22;
    #1;
    chk("t2_byp_same", 64'(b1.rd_data[63:32]), 64'(32'h11));
    chk("t2_nobyp_same", 64'(b0.rd_data[63:32]), 64'(0));
    tick();
    idle_inputs();
    #1;
    chk("t2_r7_byp", 64'(b1.rd_data[63:32]), 64'(32'h11));
    chk("t2_r7_nobyp", 64'(b0.rd_data[63:32]), 64'(32'h11));

    // Cancelled A write
    b1.rd_addr   = {5'd7, 5'd3};
    b1.wa_en     = 1'b1;
    b1.wa_addr   = 5'd3;
    b1.wa_data   = 32'h5;
    b1.wa_cancel = 1'b1;
    #1;
    chk("t3_cancel_same", 64'(b1.rd_data[31:0]), 64'(0));
    tick();
    b1.wa_en     = 1'b0;
    b1.wa_cancel = 1'b0;
    #1;
    chk("t3_cancel_r3", 64'(b1.rd_data[31:0]), 64'(0));
    chk("t3_cancel_r3_nobyp", 64'(b0.rd_data[31:0]), 64'(0));
    b1.wa_en = 1'b1;
    tick();
    b1.wa_en = 1'b0;
    #1;
    chk("t3_r3", 64'(b1.rd_data[31:0]), 64'(32'h5));
    chk("t3_r3_nobyp", 64'(b0.rd_data[31:0]), 64'(32'h5));

    // Scoreboard set / B clear / set wins
    b1.rd_addr = {5'd7, 5'd9};
    b1.sb_set  = 1'b1;
    b1.sb_addr = 5'd9;
    tick();
    b1.sb_set = 1'b0;
    #1;
    chk("t4_busy_set", 64'(b1.rd_busy), 64'(2'b01));
    chk("t4_busy_set_nobyp", 64'(b0.rd_busy), 64'(2'b01));
    b1.wb_en   = 1'b1;
    b1.wb_addr = 5'd9;
    b1.wb_data = 32'h77;
    #1;
    chk("t4_wb_byp_same", 64'(b1.rd_data[31:0]), 64'(32'h77));
    chk("t4_wb_nobyp_same", 64'(b0.rd_data[31:0]), 64'(0));
    tick();
    b1.wb_en = 1'b0;
    #1;
    chk("t4_busy_clr", 64'(b1.rd_busy), 64'(2'b00));
    chk("t4_r9", 64'(b1.rd_data[31:0]), 64'(32'h77));
    chk("t4_r9_nobyp", 64'(b0.rd_data[31:0]), 64'(32'h77));
    b1.sb_set  = 1'b1;
    b1.wb_en   = 1'b1;
    b1.wb_data = 32'h88;
    tick();
    idle_inputs();
    #1;
    chk("t4_set_wins", 64'(b1.rd_busy), 64'(2'b01));
    chk("t4_r9_88", 64'(b1.rd_data[31:0]), 64'(32'h88));

    // Dropped B write still clears; A never touches the scoreboard
    b1.rd_addr = {5'd9, 5'd10};
    b1.sb_set  = 1'b1;
    b1.sb_addr = 5'd10;
    tick();
    b1.sb_set = 1'b0;
    #1;
    chk("t4_busy_both", 64'(b1.rd_busy), 64'(2'b11));
    b1.wa_en   = 1'b1;
    b1.wa_addr = 5'd10;
    b1.wa_data = 32'hA;
    b1.wb_en   = 1'b1;
    b1.wb_addr = 5'd10;
    b1.wb_data = 32'hB;
    #1;
    chk("t4_drop_byp_same", 64'(b1.rd_data[31:0]), 64'(32'hA));
    tick();
    idle_inputs();
    #1;
    chk("t4_drop_busy", 64'(b1.rd_busy), 64'(2'b10));
    chk("t4_drop_r10", 64'(b1.rd_data[31:0]), 64'(32'hA));
    chk("t4_drop_r10_nobyp", 64'(b0.rd_data[31:0]), 64'(32'hA));
    b1.wa_en   = 1'b1;
    b1.wa_addr = 5'd9;
    b1.wa_data = 32'h99;
    tick();
    b1.wa_en = 1'b0;
    #1;
    chk("t4_a_no_sb", 64'(b1.rd_busy), 64'(2'b10));
    chk("t4_a_r9", 64'(b1.rd_data[63:32]), 64'(32'h99));

    // Soft clear over a full file
    fill();
    b1.sb_set  = 1'b1;
    b1.sb_addr = 5'd12;
    tick();
    b1.sb_set  = 1'b0;
    b1.rd_addr = {5'd31, 5'd20};
    #1;
    chk("t5_pre_r20", 64'(b1.rd_data[31:0]), 64'(32'h1014));
    chk("t5_pre_r31", 64'(b1.rd_data[63:32]), 64'(32'h101F));
    chk("t5_pre_ready", 64'(b1.ready), 64'(1));
    b1.clr_req = 1'b1;
    tick();
    b1.clr_req = 1'b0;
    for (int c = 0; c < 32; c++) begin
      #1;
      chk("t5_clr_busy", 64'(b1.clr_busy), 64'(1));
      chk("t5_clr_ready", 64'(b1.ready), 64'(0));
      chk("t5_clr_data", 64'(b1.rd_data), 64'(0));
      chk("t5_clr_rd_busy", 64'(b1.rd_busy), 64'(2'b11));
      if (c == 3) b1.clr_req = 1'b1;
      if (c == 5) begin
        b1.wa_en   = 1'b1;
        b1.wa_addr = 5'd2;
        b1.wa_data = 32'hBAD;
        b1.wb_en   = 1'b1;
        b1.wb_addr = 5'd3;
        b1.wb_data = 32'hCAB;
        b1.sb_set  = 1'b1;
        b1.sb_addr = 5'd4;
      end
      tick();
      idle_inputs();
    end
    #1;
    chk("t5_done_busy", 64'(b1.clr_busy), 64'(0));
    chk("t5_done_ready", 64'(b1.ready), 64'(1));
    chk_all_zero("t5_post_clear");
    b1.rd_addr = {5'd0, 5'd6};
    b1.wa_en   = 1'b1;
    b1.wa_addr = 5'd6;
    b1.wa_data = 32'h66;
    tick();
    b1.wa_en = 1'b0;
    #1;
    chk("t5_write_after", 64'(b0.rd_data[31:0]), 64'(32'h66));

    // Reset aborts a clear in progress
    fill();
    b1.rd_addr = {5'd31, 5'd20};
    b1.clr_req = 1'b1;
    tick();
    b1.clr_req = 1'b0;
    repeat (10) tick();
    #1;
    chk("t5_abort_busy_pre", 64'(b1.clr_busy), 64'(1));
    rst = 1'b1;
    tick();
    #1;
    chk("t5_abort_busy", 64'(b1.clr_busy), 64'(0));
    chk("t5_abort_ready", 64'(b1.ready), 64'(0));
    chk("t5_abort_data", 64'(b1.rd_data), 64'(0));
    rst = 1'b0;
    #1;
    chk("t5_abort_rstq_ready", 64'(b1.ready), 64'(0));
    tick();
    chk("t5_abort_ready_after", 64'(b1.ready), 64'(1));
    chk("t5_abort_idle", 64'(b1.clr_busy), 64'(0));
    chk_all_zero("t5_post_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
